// File: rtl/smpl_queue_pkg.sv
// Shared types and constants for the stereo sample queue.
// State encoding, default geometry and the pointer type of the default build.
package smpl_queue_pkg;

  // Default geometry: 1024-entry ring, 1021-tap readout window, 16-bit samples.
  localparam int unsigned DEPTH_DEF = 1024;
  localparam int unsigned TAPS_DEF  = 1021;
  localparam int unsigned DW_DEF    = 16;

  // Pointer width and type for the default ring depth.
  localparam int unsigned PTR_W = $clog2(DEPTH_DEF);
  typedef logic [PTR_W-1:0] ptr_t;

  // Readout sequencer states.
  //   StFill : buffer not yet holding a full window
  //   StIdle : waiting for a pending window
  //   StSeq  : streaming read addresses for the rest of a window
  //   StGap  : one dead cycle so sequencing always drops between windows
  typedef enum logic [1:0] {
    StFill,
    StIdle,
    StSeq,
    StGap
  } state_e;

endpackage

// File: rtl/dp_ram_smpl.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Contents are deliberately not reset.
module dp_ram_smpl #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  // Write port and registered read port share the clock; data lags address by one cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/smpl_queue.sv
// Stereo circular sample buffer feeding the per-band FIR filters.
//
// Every wrt_smpl strobe stores one left/right pair. Once TAPS pairs are held,
// each new pair schedules a burst readout of the newest TAPS pairs, oldest
// first, one pair per clock, framed by sequencing.
//
// Optional build macro: SMPL_QUEUE_OVR_EN adds a sticky ovr output that flags
// a write arriving while a window is still pending.
//
// Pipeline: the FSM issues read addresses (one per cycle), the RAM registers
// the data, and the output stage registers it again. A trigger write at edge N
// therefore issues its first address in the cycle after N and shows the first
// sample (with sequencing high) after edge N+2.
module smpl_queue
  import smpl_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic [DW-1:0] lft_smpl,
  input  logic [DW-1:0] rght_smpl,
  output logic          sequencing,
  output logic [DW-1:0] lft_out,
  output logic [DW-1:0] rght_out
`ifdef SMPL_QUEUE_OVR_EN
  ,
  output logic          ovr
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(TAPS + 1);

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(TAPS);
  // StSeq covers all window reads except the first, which StIdle/StFill issues.
  localparam logic [CntW-1:0] SeqLast = CntW'((TAPS > 1) ? (TAPS - 2) : 0);

  // Write side.
  logic [PtrW-1:0] new_ptr_q, new_ptr_d;
  logic [PtrW-1:0] old_ptr_q, old_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            trig;

  // Read side.
  state_e          state_q, state_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] seq_cnt_q, seq_cnt_d;
  logic            pend_q, pend_d;
  logic            issue;
  logic            take_pend;
  logic [PtrW-1:0] rd_addr;
  logic            vld_q, vld_d;

  // RAM data and output stage.
  logic [2*DW-1:0] rd_data;
  logic            sequencing_q, sequencing_d;
  logic [DW-1:0]   lft_out_q, lft_out_d;
  logic [DW-1:0]   rght_out_q, rght_out_d;

  // Sample storage; left channel occupies the upper half of each word.
  dp_ram_smpl #(
    .Depth (DEPTH),
    .Width (2 * DW),
    .AddrW (PtrW)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wrt_smpl),
    .wr_addr_i (new_ptr_q),
    .wr_data_i ({lft_smpl, rght_smpl}),
    .rd_en_i   (issue),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Write pointer, fill count and window-start pointer bookkeeping.
  always_comb begin
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    cnt_d     = cnt_q;
    if (wrt_smpl) begin
      new_ptr_d = new_ptr_q + PtrOne;
      if (cnt_q == CntFull) begin
        // Full: slide the window so old_ptr stays on the oldest of the newest TAPS.
        old_ptr_d = old_ptr_q + PtrOne;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // Any write that leaves the buffer holding a full window requests a readout.
  assign trig = wrt_smpl && (cnt_d == CntFull);

  // Readout sequencer: picks up a pending window and walks its read addresses.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    seq_cnt_d = seq_cnt_q;
    issue     = 1'b0;
    take_pend = 1'b0;
    rd_addr   = rd_ptr_q;
    unique case (state_q)
      // StFill starts a window exactly like StIdle so the first window keeps
      // the same trigger-to-output latency as every later one.
      StFill, StIdle: begin
        if (pend_q) begin
          issue     = 1'b1;
          take_pend = 1'b1;
          rd_addr   = old_ptr_q;
          rd_ptr_d  = old_ptr_q + PtrOne;
          seq_cnt_d = '0;
          state_d   = (TAPS > 1) ? StSeq : StGap;
        end
      end
      StSeq: begin
        issue     = 1'b1;
        rd_addr   = rd_ptr_q;
        rd_ptr_d  = rd_ptr_q + PtrOne;
        seq_cnt_d = seq_cnt_q + CntOne;
        if (seq_cnt_q == SeqLast) begin
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // A trigger on the same edge as a window start wins, so that write still gets its own window.
  always_comb begin
    pend_d = pend_q;
    if (take_pend) begin
      pend_d = 1'b0;
    end
    if (trig) begin
      pend_d = 1'b1;
    end
  end

  // RAM data is valid one cycle after an issued address.
  assign vld_d = issue;

  // Output stage: forward RAM data while valid, otherwise hold outputs at zero.
  always_comb begin
    sequencing_d = vld_q;
    lft_out_d    = '0;
    rght_out_d   = '0;
    if (vld_q) begin
      lft_out_d  = rd_data[2*DW-1:DW];
      rght_out_d = rd_data[DW-1:0];
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr_q    <= '0;
      old_ptr_q    <= '0;
      cnt_q        <= '0;
      state_q      <= StFill;
      rd_ptr_q     <= '0;
      seq_cnt_q    <= '0;
      pend_q       <= 1'b0;
      vld_q        <= 1'b0;
      sequencing_q <= 1'b0;
      lft_out_q    <= '0;
      rght_out_q   <= '0;
    end else begin
      new_ptr_q    <= new_ptr_d;
      old_ptr_q    <= old_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      seq_cnt_q    <= seq_cnt_d;
      pend_q       <= pend_d;
      vld_q        <= vld_d;
      sequencing_q <= sequencing_d;
      lft_out_q    <= lft_out_d;
      rght_out_q   <= rght_out_d;
    end
  end

  assign sequencing = sequencing_q;
  assign lft_out    = lft_out_q;
  assign rght_out   = rght_out_q;

`ifdef SMPL_QUEUE_OVR_EN
  logic ovr_q, ovr_d;

  // Sticky flag: a write landed while a window was already waiting to start.
  always_comb begin
    ovr_d = ovr_q | (wrt_smpl & pend_q);
  end

  // Overrun flag register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_smpl_queue.sv
// Self-checking bench for smpl_queue (default geometry 1024/1021/16).
// Each trigger write pushes the expected window start plus its capture cycle;
// the monitor pops at every window rise and checks every streamed pair.
module tb_smpl_queue;

  localparam int TAPS = 1021;

  logic        clk;
  logic        rst_n;
  logic        wrt_smpl;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
`ifdef SMPL_QUEUE_OVR_EN
  logic        ovr;
`endif

  smpl_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out)
`ifdef SMPL_QUEUE_OVR_EN
    ,
    .ovr        (ovr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected window start index and the edge that captured the trigger.
  typedef struct packed {
    int start;
    int cap_cyc;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] hist_l[$];
  logic [15:0] hist_r[$];
  int          nwr = 0;

  // Drive one write whose pair is (index, -index) since the last reset.
  task automatic write_next();
    @(negedge clk);
    wrt_smpl  = 1'b1;
    lft_smpl  = 16'(nwr);
    rght_smpl = 16'(-nwr);
    hist_l.push_back(16'(nwr));
    hist_r.push_back(16'(-nwr));
    nwr++;
    if (nwr >= TAPS) sb.push_back('{start: nwr - TAPS, cap_cyc: cyc + 1});
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  task automatic wait_seq(input logic lvl, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (sequencing !== lvl && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(sequencing), 32'(lvl));
  endtask

  // Monitor state.
  int in_win = 0;
  int mon_k = 0;
  int mon_start = -1;
  int low_run = 0;
  int last_gap = 0;
  int last_start = -1;
  int win_cnt = 0;

  always @(negedge clk) begin
    sb_t e;
    int  idx;
    if (!rst_n) begin
      in_win  = 0;
      low_run = 0;
      check_eq("rst_seq", 32'(sequencing), 32'd0);
      check_eq("rst_out", {lft_out, rght_out}, 32'd0);
    end else if (sequencing) begin
      if (in_win == 0) begin
        // Window rise: the start was issued one edge ago from writes up to two edges ago.
        last_gap  = low_run;
        low_run   = 0;
        mon_start = -1;
        while (sb.size() > 0 && sb[0].cap_cyc <= cyc - 2) begin
          e = sb.pop_front();
          mon_start = e.start;
        end
        check_eq("win_expected", 32'(mon_start >= 0), 32'd1);
        last_start = mon_start;
        in_win     = 1;
        mon_k      = 0;
        win_cnt++;
      end
      idx = mon_start + mon_k;
      if (mon_start >= 0 && mon_k < TAPS && idx < hist_l.size())
        check_eq("win_smpl", {lft_out, rght_out}, {hist_l[idx], hist_r[idx]});
      mon_k++;
    end else begin
      if (in_win != 0) begin
        check_eq("win_len", 32'(mon_k), 32'(TAPS));
        in_win = 0;
      end
      low_run++;
      check_eq("idle_out", {lft_out, rght_out}, 32'd0);
    end
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    wrt_smpl  = 1'b0;
    lft_smpl  = '0;
    rght_smpl = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_seq", 32'(sequencing), 32'd0);
`ifdef SMPL_QUEUE_OVR_EN
    check_eq("reset_ovr", 32'(ovr), 32'd0);
`endif
    rst_n = 1'b1;

    // Fill with TAPS-1 writes, one every 50 cycles: no window may appear.
    for (int i = 0; i < TAPS - 1; i++) begin
      write_next();
      repeat (48) @(negedge clk);
    end
    check_eq("fill_no_win", 32'(win_cnt), 32'd0);

    // TAPS-th write: sequencing rises after edge N+2.
    write_next();
    check_eq("lat_n0", 32'(sequencing), 32'd0);
    @(negedge clk);
    check_eq("lat_n1", 32'(sequencing), 32'd0);
    @(negedge clk);
    check_eq("lat_n2", 32'(sequencing), 32'd1);
    wait_seq(1'b0, 1100, "win1_end");
    check_eq("win1_cnt", 32'(win_cnt), 32'd1);
    check_eq("win1_start", 32'(last_start), 32'd0);

    // Next write after the window: streams 1..1021.
    repeat (5) @(negedge clk);
    write_next();
    wait_seq(1'b1, 10, "win2_rise");
    wait_seq(1'b0, 1100, "win2_end");
    check_eq("win2_start", 32'(last_start), 32'd1);

    // Writes during a window: current window unchanged, one coalesced window follows.
    repeat (5) @(negedge clk);
    write_next();
    wait_seq(1'b1, 10, "win3_rise");
    repeat (100) @(negedge clk);
    write_next();
`ifdef SMPL_QUEUE_OVR_EN
    check_eq("ovr_second", 32'(ovr), 32'd0);
`endif
    repeat (100) @(negedge clk);
    write_next();
`ifdef SMPL_QUEUE_OVR_EN
    check_eq("ovr_third", 32'(ovr), 32'd1);
`endif
    wait_seq(1'b0, 1100, "win3_end");
    check_eq("win3_start", 32'(last_start), 32'd2);
    wait_seq(1'b1, 10, "win4_rise");
    @(negedge clk);
    check_eq("gap_len", 32'(last_gap), 32'd1);
    wait_seq(1'b0, 1100, "win4_end");
    check_eq("win4_start", 32'(last_start), 32'd4);
    check_eq("win4_cnt", 32'(win_cnt), 32'd4);

    // Keep writing past the pointer wrap with irregular spacing.
    for (int j = 0; j < 200; j++) begin
      write_next();
      repeat ((j * 37) % 90 + 1) @(negedge clk);
    end
    repeat (2200) @(negedge clk);
    check_eq("wrap_drain", 32'(sb.size()), 32'd0);
    check_eq("wrap_start", 32'(last_start), 32'(nwr - TAPS));
    check_eq("wrap_idle", 32'(sequencing), 32'd0);

    // Asynchronous reset in the middle of a window.
    write_next();
    wait_seq(1'b1, 10, "rst_win_rise");
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_seq", 32'(sequencing), 32'd0);
    check_eq("arst_out", {lft_out, rght_out}, 32'd0);
`ifdef SMPL_QUEUE_OVR_EN
    check_eq("arst_ovr", 32'(ovr), 32'd0);
`endif
    sb.delete();
    hist_l.delete();
    hist_r.delete();
    nwr = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Refill with TAPS-1 writes: the buffer restarted empty, so no window.
    base = win_cnt;
    for (int i = 0; i < TAPS - 1; i++) begin
      write_next();
      @(negedge clk);
    end
    repeat (1200) @(negedge clk);
    check_eq("refill_no_win", 32'(win_cnt), 32'(base));
    check_eq("refill_seq", 32'(sequencing), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
